// File: rtl/dut_slot_controller.sv
// dut_slot_controller
//
// Sequences the experimental effect slot in the audio chain. The raw buttons are
// debounced on the audio sample rate. A debounced press of button 0 engages or
// bypasses the slot through a linear crossfade between dry (slot input) and
// wet (slot output). Buttons 2 and 1 are forwarded, debounced, to the slot.
// All state advances only on sample_tick_i.
//
// Ports
//   clk_i          system clock
//   srst_n_i       synchronous reset, active low
//   sample_tick_i  one-clk strobe per audio sample
//   buttons_i      raw buttons: [0] engage/bypass toggle, [2:1] forwarded to the slot
//   dry_i          slot input sample (signed)
//   wet_i          slot output sample (signed), valid while sample_tick_i is high
//   data_o         crossfaded sample (signed), valid the clk after sample_tick_i
//   dut_buttons_o  {debounced[2:1], 1'b0}
//   active_o       high in FADE_IN or ACTIVE
//   fading_o       high in FADE_IN or FADE_OUT

module dut_slot_controller #(
  parameter int DWIDTH         = 16,
  parameter int GWIDTH         = 8,
  parameter int FADE_STEP      = 4,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic                     clk_i,
  input  logic                     srst_n_i,
  input  logic                     sample_tick_i,
  input  logic [2:0]               buttons_i,
  input  logic signed [DWIDTH-1:0] dry_i,
  input  logic signed [DWIDTH-1:0] wet_i,
  output logic signed [DWIDTH-1:0] data_o,
  output logic [2:0]               dut_buttons_o,
  output logic                     active_o,
  output logic                     fading_o
);

  localparam int FULL = 2 ** GWIDTH;
  localparam int GW1  = GWIDTH + 1;
  localparam int PW   = DWIDTH + GWIDTH + 2;
  localparam int CW   = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [GW1-1:0] FULL_G  = GW1'(FULL);
  localparam logic [GW1-1:0] STEP_G  = GW1'(FADE_STEP);
  localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    S_BYPASS,
    S_FADE_IN,
    S_ACTIVE,
    S_FADE_OUT
  } state_t;

  // ---------------------------------------------------------------------------
  // Debounce, one counter per button
  // ---------------------------------------------------------------------------
  logic [2:0] db_d;

  for (genvar gi = 0; gi < 3; gi++) begin : g_db
    logic          bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      bit_d = bit_q;
      cnt_d = cnt_q;
      if (sample_tick_i) begin
        if (buttons_i[gi] != bit_q) begin
          // The read that brings the run to DEBOUNCE_TICKS commits the new level.
          if (cnt_q == DB_LAST) begin
            bit_d = buttons_i[gi];
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
        bit_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        bit_q <= bit_d;
        cnt_q <= cnt_d;
      end
    end

    assign db_d[gi] = bit_d;
  end

  logic db0_q;
  assign db0_q = g_db[0].bit_q;

  // Only the press of button 0 toggles; its release is ignored. db_d can only
  // change on a tick, so toggle is implicitly qualified by sample_tick_i.
  logic toggle;
  assign toggle = db_d[0] & ~db0_q;

  // ---------------------------------------------------------------------------
  // FSM and gain
  // ---------------------------------------------------------------------------
  state_t                    state_q, state_d;
  logic [GW1-1:0]            g_q, g_d;
  logic signed [DWIDTH-1:0]  data_q, data_d;
  logic [2:0]                btn_q, btn_d;
  logic                      active_q, active_d;
  logic                      fading_q, fading_d;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    if (sample_tick_i) begin
      // On a toggle tick only the direction flips; g holds so the fade
      // reverses from where it currently is.
      case (state_q)
        S_BYPASS: begin
          g_d = '0;
          if (toggle) state_d = S_FADE_IN;
        end
        S_FADE_IN: begin
          if (toggle) begin
            state_d = S_FADE_OUT;
          end else if (g_q >= FULL_G - STEP_G) begin
            g_d     = FULL_G;
            state_d = S_ACTIVE;
          end else begin
            g_d = g_q + STEP_G;
          end
        end
        S_ACTIVE: begin
          g_d = FULL_G;
          if (toggle) state_d = S_FADE_OUT;
        end
        S_FADE_OUT: begin
          if (toggle) begin
            state_d = S_FADE_IN;
          end else if (g_q <= STEP_G) begin
            g_d     = '0;
            state_d = S_BYPASS;
          end else begin
            g_d = g_q - STEP_G;
          end
        end
        default: begin
          g_d     = '0;
          state_d = S_BYPASS;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Crossfade datapath, using the gain in force before this tick's update
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] wet_x, dry_x, g_x, gc_x, mix;
  logic                 unused_mix_bits;

  always_comb begin
    wet_x = PW'(wet_i);
    dry_x = PW'(dry_i);
    g_x   = PW'({1'b0, g_q});
    gc_x  = PW'(FULL) - g_x;
    mix   = wet_x * g_x + dry_x * gc_x;
  end

  // Taking the slice above GWIDTH is the arithmetic (floor) shift; the
  // convex combination always fits in DWIDTH, so the top bits are sign copies.
  assign unused_mix_bits = ^{mix[PW-1:GWIDTH+DWIDTH], mix[GWIDTH-1:0]};

  always_comb begin
    data_d   = data_q;
    if (sample_tick_i) data_d = mix[GWIDTH +: DWIDTH];
    btn_d    = {db_d[2:1], 1'b0};
    active_d = (state_d == S_FADE_IN) || (state_d == S_ACTIVE);
    fading_d = (state_d == S_FADE_IN) || (state_d == S_FADE_OUT);
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q  <= S_BYPASS;
      g_q      <= '0;
      data_q   <= '0;
      btn_q    <= '0;
      active_q <= 1'b0;
      fading_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      data_q   <= data_d;
      btn_q    <= btn_d;
      active_q <= active_d;
      fading_q <= fading_d;
    end
  end

  assign data_o        = data_q;
  assign dut_buttons_o = btn_q;
  assign active_o      = active_q;
  assign fading_o      = fading_q;

endmodule
